// File: rtl/network_types.sv
// Shared TCP tx types: metadata/status word layouts, arbiter state encoding,
// status error field position and the perf counter window.
package network_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] session;
  } tcp_tx_meta_t;

  typedef struct packed {
    logic [2:0]  error;
    logic [28:0] rsvd;
    logic [15:0] length;
    logic [15:0] session;
  } tcp_tx_sts_t;

  localparam int TCP_STS_ERR_MSB = 63;
  localparam int TCP_STS_ERR_LSB = 61;

  localparam logic [63:0] PERF_WINDOW = 64'd750000000;

endpackage

// File: rtl/tcp_tx_tag_fifo.sv
// In-order FIFO of requester tags; a push and a pop in the same cycle are both
// honoured, including a push while full when the head is popped.
module tcp_tx_tag_fifo #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_tag;
  end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Per-message round-robin share of the TCP tx path with in-order status return.
// Optional perf counters are built when TCP_TX_ARB_PERF_EN is defined.
module tcp_tx_arbiter
  import network_types::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 512,
  parameter int TAG_DEPTH = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req_meta_valid,
  output logic [NUM_REQ-1:0]        req_meta_ready,
  input  logic [NUM_REQ*32-1:0]     req_meta_data,
  input  logic [NUM_REQ-1:0]        req_data_valid,
  output logic [NUM_REQ-1:0]        req_data_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_keep,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_sts_valid,
  input  logic [NUM_REQ-1:0]        req_sts_ready,
  output logic [63:0]               req_sts_data,
  output logic                      m_meta_valid,
  input  logic                      m_meta_ready,
  output logic [31:0]               m_meta_data,
  output logic                      m_data_valid,
  input  logic                      m_data_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [DATA_W/8-1:0]       m_keep,
  output logic                      m_last,
  input  logic                      s_sts_valid,
  output logic                      s_sts_ready,
  input  logic [63:0]               s_sts_data,
`ifdef TCP_TX_ARB_PERF_EN
  output logic [31:0]               perf_msg_cnt,
  output logic [63:0]               perf_tx_bytes,
  output logic [31:0]               perf_err_cnt,
  output logic [63:0]               perf_cycles,
`endif
  output logic                      sts_orphan,
  output arb_state_t                fsm_state
);

  // All channels are valid/ready: a beat transfers on a clock edge where both
  // are high; valid never waits on ready, ready may depend on valid.

  localparam int GW = $clog2(NUM_REQ);
  localparam int KW = DATA_W / 8;

  arb_state_t   state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner;
  logic [GW-1:0] next_ptr;
  logic          found;
  tcp_tx_meta_t  meta_q;
  logic          meta_valid;
  logic          meta_hs;
  logic          data_hs;

  logic          tag_full;
  logic          tag_empty;
  logic [GW-1:0] tag_head;
  logic          sts_pop;

  logic [31:0]     meta_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [KW-1:0]   keep_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign meta_arr[g] = req_meta_data[g*32 +: 32];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    assign keep_arr[g] = req_keep[g*KW +: KW];
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin : arb_search
    int idx;
    logic [GW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx  = (int'(rr_ptr) + i) % NUM_REQ;
      cand = GW'(idx);
      if (!found && req_meta_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign next_ptr = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign meta_hs  = meta_valid & m_meta_ready;
  assign data_hs  = (state == DATA) & req_data_valid[grant] & m_data_ready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      meta_q     <= '0;
      meta_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found && !tag_full) begin
            grant      <= winner;
            meta_q     <= meta_arr[winner];
            meta_valid <= 1'b1;
            state      <= META;
          end
        end
        META: begin
          if (meta_hs) begin
            meta_valid <= 1'b0;
            if (meta_q.length != 16'd0) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        DATA: begin
          if (data_hs && req_last[grant]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_meta_valid = meta_valid;
  assign m_meta_data  = meta_q;
  assign fsm_state    = state;

  always_comb begin
    req_meta_ready = '0;
    req_data_ready = '0;
    m_data_valid   = 1'b0;
    m_data         = '0;
    m_keep         = '0;
    m_last         = 1'b0;
    if (meta_hs) req_meta_ready[grant] = 1'b1;
    if (state == DATA) begin
      m_data_valid          = req_data_valid[grant];
      m_data                = data_arr[grant];
      m_keep                = keep_arr[grant];
      m_last                = req_last[grant];
      req_data_ready[grant] = m_data_ready;
    end
  end

  // Statuses come back in metadata order; with no tag outstanding they are
  // swallowed so the stack never stalls.
  always_comb begin
    req_sts_valid = '0;
    req_sts_data  = '0;
    s_sts_ready   = 1'b1;
    if (!tag_empty) begin
      req_sts_valid[tag_head] = s_sts_valid;
      s_sts_ready             = req_sts_ready[tag_head];
      req_sts_data            = s_sts_data;
    end
  end

  assign sts_pop = ~tag_empty & s_sts_valid & s_sts_ready;

  always_ff @(posedge aclk) begin
    if (areset) sts_orphan <= 1'b0;
    else if (tag_empty && s_sts_valid) sts_orphan <= 1'b1;
  end

  tcp_tx_tag_fifo #(
    .TAG_W (GW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (aclk),
    .rst      (areset),
    .push     (meta_hs),
    .push_tag (grant),
    .pop      (sts_pop),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

`ifdef TCP_TX_ARB_PERF_EN
  logic perf_run;
  logic sts_hs;

  assign sts_hs = s_sts_valid & s_sts_ready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      perf_run      <= 1'b0;
      perf_msg_cnt  <= '0;
      perf_tx_bytes <= '0;
      perf_err_cnt  <= '0;
      perf_cycles   <= '0;
    end else if (perf_cycles == PERF_WINDOW) begin
      perf_msg_cnt  <= '0;
      perf_tx_bytes <= '0;
      perf_err_cnt  <= '0;
      perf_cycles   <= '0;
    end else begin
      if (meta_hs) begin
        perf_run     <= 1'b1;
        perf_msg_cnt <= perf_msg_cnt + 32'd1;
      end
      if (perf_run || meta_hs) perf_cycles <= perf_cycles + 64'd1;
      if (sts_hs) begin
        if (s_sts_data[TCP_STS_ERR_MSB:TCP_STS_ERR_LSB] == 3'd0)
          perf_tx_bytes <= perf_tx_bytes + 64'(s_sts_data[31:16]);
        else
          perf_err_cnt <= perf_err_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: message vector table plus hand sequences
// for tag FIFO full, orphan status and reset mid-message.
module tb_tcp_tx_arbiter;
  import network_types::*;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int TAG_DEPTH = 16;
  localparam int KW        = DATA_W / 8;

  logic                      clk;
  logic                      areset;
  logic [NUM_REQ-1:0]        req_meta_valid;
  logic [NUM_REQ-1:0]        req_meta_ready;
  logic [NUM_REQ*32-1:0]     req_meta_data;
  logic [NUM_REQ-1:0]        req_data_valid;
  logic [NUM_REQ-1:0]        req_data_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*KW-1:0]     req_keep;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_sts_valid;
  logic [NUM_REQ-1:0]        req_sts_ready;
  logic [63:0]               req_sts_data;
  logic                      m_meta_valid;
  logic                      m_meta_ready;
  logic [31:0]               m_meta_data;
  logic                      m_data_valid;
  logic                      m_data_ready;
  logic [DATA_W-1:0]         m_data;
  logic [KW-1:0]             m_keep;
  logic                      m_last;
  logic                      s_sts_valid;
  logic                      s_sts_ready;
  logic [63:0]               s_sts_data;
  logic                      sts_orphan;
  arb_state_t                fsm_state;

  tcp_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .aclk           (clk),
    .areset         (areset),
    .req_meta_valid (req_meta_valid),
    .req_meta_ready (req_meta_ready),
    .req_meta_data  (req_meta_data),
    .req_data_valid (req_data_valid),
    .req_data_ready (req_data_ready),
    .req_data       (req_data),
    .req_keep       (req_keep),
    .req_last       (req_last),
    .req_sts_valid  (req_sts_valid),
    .req_sts_ready  (req_sts_ready),
    .req_sts_data   (req_sts_data),
    .m_meta_valid   (m_meta_valid),
    .m_meta_ready   (m_meta_ready),
    .m_meta_data    (m_meta_data),
    .m_data_valid   (m_data_valid),
    .m_data_ready   (m_data_ready),
    .m_data         (m_data),
    .m_keep         (m_keep),
    .m_last         (m_last),
    .s_sts_valid    (s_sts_valid),
    .s_sts_ready    (s_sts_ready),
    .s_sts_data     (s_sts_data),
    .sts_orphan     (sts_orphan),
    .fsm_state      (fsm_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;
  int waited;
  int sts_cnt = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] len;
    int          beats;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_word(input int r, input int b);
    return 32'hC0DE_0000 | (32'(r) << 8) | 32'(b);
  endfunction

  // Drivers
  task automatic set_meta(input logic [3:0] mask, input logic [15:0] len);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_meta_valid[i] = mask[i];
      req_meta_data[i*32 +: 32] = {len, 16'h0100 + 16'(i)};
    end
  endtask

  task automatic wait_meta();
    waited = 0;
    while (!m_meta_valid && waited < 40) begin
      tick();
      waited++;
    end
  endtask

  task automatic drive_beat(input logic [3:0] mask, input int b, input logic last);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data_valid[i]     = mask[i];
      req_data[i*32 +: 32]  = beat_word(i, b);
      req_keep[i*KW +: KW]  = KW'(i + 1);
      req_last[i]           = last;
    end
  endtask

  task automatic do_msg(input vec_t v);
    set_meta(v.mask, v.len);
    wait_meta();
    chk("meta_valid", 64'(m_meta_valid), 64'd1);
    chk("meta_data", 64'(m_meta_data), 64'({v.len, 16'h0100 + 16'(v.exp_grant)}));
    chk("meta_ready", 64'(req_meta_ready), 64'(4'b0001 << v.exp_grant));
    exp_q.push_back(v.exp_grant);
    tick();
    req_meta_valid = '0;
    if (v.len == 16'd0) begin
      #1;
      chk("zero_len_idle", 64'({m_meta_valid, fsm_state}), 64'({1'b0, IDLE}));
    end else begin
      for (int b = 0; b < v.beats; b++) begin
        drive_beat(v.mask, b, (b == v.beats - 1));
        #1;
        chk("data_beat",
            64'({m_data_valid, m_last, m_keep, req_data_ready, m_data}),
            64'({1'b1, (b == v.beats - 1), KW'(v.exp_grant + 1), 4'b0001 << v.exp_grant,
                 beat_word(int'(v.exp_grant), b)}));
        tick();
      end
      req_data_valid = '0;
      req_last       = '0;
    end
  endtask

  task automatic ret_sts(input logic [2:0] err, input logic [15:0] len, input bit stall);
    logic [1:0]  tag;
    logic [63:0] word;
    if (exp_q.size() == 0) begin
      chk("sts_expected_tag", 64'(exp_q.size()), 64'd1);
    end else begin
      tag  = exp_q.pop_front();
      word = {err, 29'h0, len, 16'h0100 + 16'(tag)};
      s_sts_valid = 1'b1;
      s_sts_data  = word;
      if (stall) begin
        req_sts_ready = '0;
        #1;
        chk("sts_stall", 64'({s_sts_ready, req_sts_valid}), 64'({1'b0, 4'b0001 << tag}));
        tick();
      end
      req_sts_ready = 4'b0001 << tag;
      #1;
      chk("sts_route", 64'({s_sts_ready, req_sts_valid}), 64'({1'b1, 4'b0001 << tag}));
      chk("sts_data", req_sts_data, word);
      tick();
      s_sts_valid   = 1'b0;
      req_sts_ready = '0;
      sts_cnt++;
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name,
        64'({m_meta_valid, m_data_valid, req_meta_ready, req_data_ready, req_sts_valid,
             s_sts_ready, sts_orphan, fsm_state, m_meta_data}),
        64'({1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, IDLE, 32'h0}));
  endtask

  initial begin
    vecs[0] = '{4'b0010, 16'd128, 2, 2'd1};
    vecs[1] = '{4'b1101, 16'd64,  1, 2'd2};
    vecs[2] = '{4'b1101, 16'd16,  1, 2'd3};
    vecs[3] = '{4'b1101, 16'd100, 2, 2'd0};
    vecs[4] = '{4'b1101, 16'd8,   1, 2'd2};
    vecs[5] = '{4'b1001, 16'd24,  1, 2'd3};
    vecs[6] = '{4'b0100, 16'd0,   0, 2'd2};
    vecs[7] = '{4'b1111, 16'd32,  1, 2'd3};
    vecs[8] = '{4'b1111, 16'd40,  3, 2'd0};

    // Reset
    areset         = 1'b1;
    req_meta_valid = '0;
    req_meta_data  = '0;
    req_data_valid = '0;
    req_data       = '0;
    req_keep       = '0;
    req_last       = '0;
    req_sts_ready  = '0;
    m_meta_ready   = 1'b1;
    m_data_ready   = 1'b1;
    s_sts_valid    = 1'b0;
    s_sts_data     = '0;
    repeat (3) tick();
    areset = 1'b0;
    #1;
    chk_reset_outputs("reset_state");

    // Message table
    for (int k = 0; k < 9; k++) begin
      do_msg(vecs[k]);
      if (k == 0) chk("meta_latency", 64'(waited), 64'd1);
    end

    // Return statuses in metadata order; first one with requester backpressure
    for (int k = 0; k < 9; k++)
      ret_sts((k % 2 == 1) ? 3'b101 : 3'b000, 16'(64 + k), (k == 0));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Tag FIFO full: 16 outstanding zero-length messages block the 17th
    for (int k = 0; k < TAG_DEPTH; k++) do_msg('{4'b0001, 16'd0, 0, 2'd0});
    set_meta(4'b0001, 16'd0);
    repeat (6) tick();
    chk("full_blocks", 64'({m_meta_valid, fsm_state}), 64'({1'b0, IDLE}));
    ret_sts(3'b000, 16'd1, 1'b0);
    do_msg('{4'b0001, 16'd0, 0, 2'd0});
    chk("full_resume_latency", 64'(waited), 64'd1);
    while (exp_q.size() > 0) ret_sts(3'b000, 16'd2, 1'b0);

    // Orphan status with an empty tag FIFO
    s_sts_valid   = 1'b1;
    s_sts_data    = 64'hE000_0000_0010_0000;
    req_sts_ready = '0;
    #1;
    chk("orphan_accept", 64'({s_sts_ready, req_sts_valid, sts_orphan}), 64'({1'b1, 4'b0, 1'b0}));
    tick();
    s_sts_valid = 1'b0;
    chk("orphan_set", 64'(sts_orphan), 64'd1);
    repeat (3) tick();
    chk("orphan_sticky", 64'(sts_orphan), 64'd1);

    // Reset mid-DATA on requester 0 after 3 of 8 beats
    set_meta(4'b0001, 16'd512);
    wait_meta();
    chk("mid_meta_valid", 64'(m_meta_valid), 64'd1);
    tick();
    req_meta_valid = '0;
    for (int b = 0; b < 3; b++) begin
      drive_beat(4'b0001, b, 1'b0);
      #1;
      chk("mid_data_beat", 64'({m_data_valid, req_data_ready, m_data}),
          64'({1'b1, 4'b0001, beat_word(0, b)}));
      tick();
    end
    areset = 1'b1;
    set_meta(4'b0010, 16'd0);
    tick();
    chk_reset_outputs("mid_reset_state");
    areset = 1'b0;
    req_data_valid = '0;
    exp_q.delete();
    do_msg('{4'b0010, 16'd0, 0, 2'd1});
    ret_sts(3'b000, 16'd0, 1'b0);
    chk("post_reset_drained", 64'({s_sts_ready, req_sts_valid}), 64'({1'b1, 4'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_tx_arbiter.md
Name: tcp_tx_arbiter

Overview:
- Shares the single TCP transmit path of the network stack (tx metadata, tx data, tx status) between NUM_REQ independent requesters, such as application kernels or per-session producers.
- Round-robin arbitration is done per message: a granted requester owns the metadata and data channels until its last data beat.
- Tx status responses return in metadata order and are routed back to the originating requester through an in-order tag FIFO.
- Sits between the user kernels and the stack's s_axis_tx_metadata / s_axis_tx_data / m_axis_tx_status.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 512, tx data width in bits.
- TAG_DEPTH, 16, outstanding-status tag FIFO depth (power of 2).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- req_meta_valid  in  NUM_REQ  per-requester metadata valid.
- req_meta_ready  out  NUM_REQ  per-requester metadata ready.
- req_meta_data  in  NUM_REQ*32  per requester: [15:0] session id, [31:16] length in bytes.
- req_data_valid  in  NUM_REQ  per-requester data valid.
- req_data_ready  out  NUM_REQ  per-requester data ready.
- req_data  in  NUM_REQ*DATA_W  per-requester data payload.
- req_keep  in  NUM_REQ*DATA_W/8  per-requester byte keep.
- req_last  in  NUM_REQ  per-requester last beat.
- req_sts_valid  out  NUM_REQ  per-requester status valid.
- req_sts_ready  in  NUM_REQ  per-requester status ready.
- req_sts_data  out  64  status word, shared by all requesters; qualified by req_sts_valid.
- m_meta_valid / m_meta_ready / m_meta_data  out/in/out  1/1/32  to stack tx metadata.
- m_data_valid / m_data_ready  out/in  1/1  to stack tx data.
- m_data / m_keep / m_last  out  DATA_W / DATA_W/8 / 1  to stack tx data.
- s_sts_valid / s_sts_ready / s_sts_data  in/out/in  1/1/64  from stack tx status; [63:61] error, [31:16] length.
- sts_orphan  out  1  sticky: a status arrived while the tag FIFO was empty.

Behaviour:
- FSM states: IDLE, META, DATA. The grant index and metadata word are registered.
- IDLE:
  - Arbitrates only when the tag FIFO is not full.
  - Winner is the first requester with req_meta_valid=1, searching from rr_ptr upward with wrap-around.
  - Latch grant and metadata; go to META.
  - req_meta_ready stays 0 in IDLE.
- META:
  - m_meta_valid=1 with the latched data; metadata reaches the output one cycle after the grant.
  - req_meta_ready[grant] pulses in the same cycle as the m_meta handshake, so the requester's word is consumed exactly once.
  - On the handshake: push grant into the tag FIFO.
  - Next state is DATA if length != 0. If length == 0, go to IDLE and set rr_ptr = grant+1 mod NUM_REQ.
- DATA:
  - Combinational pass-through from the granted requester only: m_data_valid = req_data_valid[grant], req_data_ready[grant] = m_data_ready.
  - All other req_data_ready are 0.
  - On a handshake with last=1: go to IDLE and set rr_ptr = grant+1 mod NUM_REQ.
  - Beat count is not checked against length.
- Status path (independent of the FSM, combinational):
  - With the FIFO not empty: head = tag FIFO head, req_sts_valid[head] = s_sts_valid, s_sts_ready = req_sts_ready[head], req_sts_data = s_sts_data.
  - Pop on the s_sts handshake.
  - With the FIFO empty: s_sts_ready=1, the status is dropped and sts_orphan is set; it clears only on reset.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Reset values: FSM=IDLE, rr_ptr=0, FIFO empty, all valid/ready outputs 0 (s_sts_ready=1 once the FIFO is empty out of reset), sts_orphan=0, data outputs 0.
- Reset mid-message: in-flight state and tags are discarded; there is no partial replay.

Optional Feature:
- Macro: TCP_TX_ARB_PERF_EN.
- With the macro defined:
  - Adds outputs perf_msg_cnt[31:0] (m_meta handshakes).
  - Adds perf_tx_bytes[63:0]: sum of status length for statuses with error==0.
  - Adds perf_err_cnt[31:0]: statuses with error!=0.
  - Adds perf_cycles[63:0]: counts from the first m_meta handshake.
  - All four clear together when perf_cycles reaches 750000000, and on reset.
- Without the macro: these ports and registers do not exist.

Decomposition:
- Shared package (network_types):
  - tcp_tx_meta_t: session[15:0], length[15:0].
  - tcp_tx_sts_t: error[2:0], length, session.
  - TCP_STS_ERR_MSB / LSB constants.
  - Perf window constant 750000000.
- One sub-module: tcp_tx_tag_fifo, a synchronous FIFO of $clog2(NUM_REQ)-bit tags with full/empty and a same-cycle push/pop.

Test Plan:
- Single requester 1, length 128, 2 beats: metadata out one cycle after grant; 2 data beats; status with error=0 routed only to req_sts_valid[1].
- Requesters 0, 2 and 3 all valid continuously: grant order 0,2,3,0…; no data interleaving within a message.
- Length=0 on requester 2: metadata forwarded, no data state entered, the next grant goes to requester 3.
- TAG_DEPTH=16 with no status returned: the 17th message is not arbitrated until one status pops.
- Status injected with the FIFO empty: s_sts_ready=1, no req_sts_valid asserted, sts_orphan=1 until reset.
- areset asserted mid-DATA on requester 0 after 3 of 8 beats: all outputs return to reset values next cycle, and a fresh request from requester 1 is granted first.
